keypad_entry: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces one key at a time and shifts each accepted hex digit into a 16-bit entry register. It is the input-side counterpart of the multiplexed seven-segment display: the display drives digits out one anode at a time, and this block drives keypad columns one at a time and reads rows back. Its `dat` output feeds the display's 16-bit data bus directly. It shares the system 1 ms clock-enable strobe with the display and debouncer.

---
 rtl/keypad_entry.sv | 155 +++++++++++++++
 tb/tb_keypad_entry.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
// 4x4 active-low keypad scanner with per-key debounce; accepted hex digits
// shift into a 16-bit entry register (newest digit in [3:0]).
module keypad_entry #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [15:0] dat,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        pressed
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_MS);

  state_t      state_q, state_d;
  logic [3:0]  sync_q, row_s_q;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  col_q, col_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] dat_q, dat_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        pressed_q, pressed_d;

  logic [7:0]  cnt_inc;
  logic        cnt_done;
  logic        latched_low;
  logic [1:0]  low_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      row_s_q <= '1;
    end else begin
      sync_q  <= row;
      row_s_q <= sync_q;
    end
  end

  // Lowest-indexed low row wins when several are pressed in one column.
  always_comb begin
    low_idx = 2'd3;
    if (!row_s_q[0])      low_idx = 2'd0;
    else if (!row_s_q[1]) low_idx = 2'd1;
    else if (!row_s_q[2]) low_idx = 2'd2;
  end

  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign cnt_done    = (cnt_inc >= DB_LIMIT);
  assign latched_low = ~row_s_q[row_idx_q];

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    dat_d       = dat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    pressed_d   = 1'b0;

    case (state_q)
      SCAN: begin
        if (ce1ms) begin
          if (row_s_q != 4'hF) begin
            row_idx_d = low_idx;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (ce1ms) begin
          if (latched_low) begin
            cnt_d = cnt_inc;
            if (cnt_done) state_d = ACCEPT;
          end else begin
            state_d = SCAN;
          end
        end
      end
      ACCEPT: begin
        key_valid_d = 1'b1;
        key_code_d  = {row_idx_q, col_idx_q};
        dat_d       = {dat_q[11:0], row_idx_q, col_idx_q};
        cnt_d       = '0;
        state_d     = RELEASE;
      end
      RELEASE: begin
        // pressed is held low on the exit edge so it falls with the col advance
        pressed_d = 1'b1;
        if (ce1ms) begin
          if (!latched_low) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              state_d   = SCAN;
              pressed_d = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
              col_d     = {col_q[2:0], col_q[3]};
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    if (clr) dat_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      col_q       <= 4'b1110;
      cnt_q       <= '0;
      dat_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      pressed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      dat_q       <= dat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      pressed_q   <= pressed_d;
    end
  end

  assign col       = col_q;
  assign dat       = dat_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
// Bench for keypad_entry: a keypad matrix model drives rows from the scanned
// columns; accepted keys are predicted into a queue and checked by a monitor.
module tb_keypad_entry;

  localparam int unsigned DB     = 3;
  localparam int unsigned CE_DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce1ms = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] dat;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        pressed;

  logic [15:0] keys = '0;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] m_dat = '0;
  logic        prev_valid = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  logic [1:0]  r_col;
  logic [3:0]  r_rows;
  logic [15:0] r_mask;

  keypad_entry #(.DEBOUNCE_MS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce1ms    (ce1ms),
    .row      (row),
    .clr      (clr),
    .col      (col),
    .dat      (dat),
    .key_code (key_code),
    .key_valid(key_valid),
    .pressed  (pressed)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low when any held key on it sits in a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  initial begin
    forever begin
      repeat (CE_DIV - 1) @(posedge clk);
      #1 ce1ms = 1'b1;
      @(posedge clk);
      #1 ce1ms = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (prev_valid) check("pressed_after_valid", {31'b0, pressed}, 32'd1);
    if (key_valid) begin
      check("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_key: got key_code=%h dat=%h, required no key (t=%0t)",
                 key_code, dat, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("key_code", {28'b0, key_code}, {28'b0, mon_e.code});
        check("dat", {16'b0, dat}, {16'b0, mon_e.dat});
      end
    end
    if (ce1ms && rst) check("col_one_low", $countones(~col), 32'd1);
    prev_valid <= key_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic wait_ce();
    do @(posedge clk); while (ce1ms !== 1'b1);
    #1;
  endtask

  task automatic wait_ms(input int n);
    repeat (n) wait_ce();
  endtask

  task automatic wait_col(input logic [3:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      wait_ce();
      if (col === target) found = 1'b1;
    end
    check("col_align", {31'b0, found}, 32'd1);
  endtask

  function automatic logic [3:0] first_key(input logic [15:0] m);
    first_key = 4'h0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) first_key = 4'(i);
  endfunction

  task automatic expect_key(input logic [3:0] code, input logic cleared);
    if (cleared) m_dat = '0;
    else         m_dat = {m_dat[11:0], code};
    exp_q.push_back({code, m_dat});
  endtask

  task automatic press(input logic [15:0] m, input int hold, input int gap);
    expect_key(first_key(m), 1'b0);
    keys = m;
    wait_ms(hold);
    keys = '0;
    wait_ms(gap);
  endtask

  task automatic do_reset();
    check("idle_before_reset", exp_q.size(), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_col", {28'b0, col}, 32'hE);
    check("rst_dat", {16'b0, dat}, 32'h0);
    check("rst_key_code", {28'b0, key_code}, 32'h0);
    check("rst_key_valid", {31'b0, key_valid}, 32'h0);
    check("rst_pressed", {31'b0, pressed}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_dat = '0;
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("init_col", {28'b0, col}, 32'hE);
    check("init_dat", {16'b0, dat}, 32'h0);
    check("init_key_valid", {31'b0, key_valid}, 32'h0);
    check("init_pressed", {31'b0, pressed}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // clean press of key 9 (row 2, column 1)
    wait_col(4'b1101);
    expect_key(4'h9, 1'b0);
    keys = 16'h0200;
    wait_ms(8);
    check("clean_pressed", {31'b0, pressed}, 32'd1);
    check("clean_col_held", {28'b0, col}, 32'hD);
    check("clean_code", {28'b0, key_code}, 32'h9);
    check("clean_dat", {16'b0, dat}, 32'h0009);
    keys = '0;
    wait_ms(2);
    check("release_still_pressed", {31'b0, pressed}, 32'd1);
    wait_ms(1);
    check("release_done", {31'b0, pressed}, 32'd0);
    check("release_col_next", {28'b0, col}, 32'hB);
    wait_ms(3);

    // asynchronous reset mid-scan
    repeat (3) @(posedge clk);
    do_reset();

    // sequence and overflow: 1,2,3,4,5
    for (int k = 1; k <= 5; k++) press(16'(1 << k), 14, 7);
    check("seq_final_dat", {16'b0, dat}, 32'h2345);

    // bounce on key 0: low, high, low, low, low, low
    wait_col(4'b1110);
    keys = 16'h0001;
    wait_ce();
    keys = '0;
    wait_ce();
    keys = 16'h0001;
    expect_key(4'h0, 1'b0);
    wait_ms(2);
    check("bounce_no_early_valid", {31'b0, key_valid}, 32'd0);
    check("bounce_no_early_press", {31'b0, pressed}, 32'd0);
    wait_ms(2);
    check("bounce_pre_accept", {31'b0, key_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("bounce_accept", {31'b0, key_valid}, 32'd1);
    check("bounce_code", {28'b0, key_code}, 32'h0);
    wait_ms(4);
    keys = '0;
    wait_ms(6);

    // priority (rows 1 and 3 on column 0) and no rollover to key F
    expect_key(4'h4, 1'b0);
    keys = 16'h1010;
    wait_ms(14);
    check("prio_code", {28'b0, key_code}, 32'h4);
    keys = 16'h9010;
    wait_ms(8);
    check("rollover_held", {31'b0, pressed}, 32'd1);
    expect_key(4'hF, 1'b0);
    keys = 16'h8000;
    wait_ms(14);
    keys = '0;
    wait_ms(7);

    // clr colliding with the accept of key 7
    do_reset();
    for (int k = 1; k <= 4; k++) press(16'(1 << k), 14, 7);
    check("clr_pre_dat", {16'b0, dat}, 32'h1234);
    expect_key(4'h7, 1'b1);
    keys = 16'h0080;
    repeat (14) begin
      wait_ce();
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
    end
    keys = '0;
    wait_ms(7);
    check("clr_dat", {16'b0, dat}, 32'h0);
    check("clr_code", {28'b0, key_code}, 32'h7);

    // reset mid-debounce of key 5 abandons it
    wait_col(4'b1101);
    keys = 16'h0020;
    wait_ms(2);
    do_reset();
    keys = '0;
    wait_ms(6);

    // randomized presses, possibly several rows in one column
    for (int i = 0; i < 10; i++) begin
      r_col  = 2'($urandom_range(0, 3));
      r_rows = 4'($urandom_range(1, 15));
      r_mask = '0;
      for (int r = 0; r < 4; r++)
        if (r_rows[r]) r_mask[r*4 + int'(r_col)] = 1'b1;
      repeat ($urandom_range(0, 7)) @(posedge clk);
      #1;
      press(r_mask, int'($urandom_range(12, 20)), int'($urandom_range(6, 10)));
    end

    wait_ms(2);
    check("all_keys_seen", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
